// File: rtl/fp_accumulator.sv
// FP32 truncating accumulator: IDLE -> ALIGN -> ADD, one product accepted per three cycles.
// Optional sticky saturation flag output acc_ovf is enabled by defining FPACC_OVF_FLAG_EN.
module fp_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             acc_clear,
    output logic [31:0]      acc_out,
    output logic             out_valid,
    output logic [CNT_W-1:0] acc_cnt
`ifdef FPACC_OVF_FLAG_EN
    ,
    output logic             acc_ovf
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_ADD   = 2'd2
    } state_t;

    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) begin
                n = 5'(23 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    state_t             r_state;
    state_t             w_next_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [31:0]        r_acc;
    logic [31:0]        r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_accept;

    logic               r_res_sign;
    logic               r_sub;
    logic [7:0]         r_big_exp;
    logic [23:0]        r_big_man;
    logic [23:0]        r_sml_man;

    logic               w_a_zero;
    logic               w_b_zero;
    logic               w_big_zero;
    logic               w_sml_zero;
    logic [30:0]        w_a_mag;
    logic [30:0]        w_b_mag;
    logic [31:0]        w_big;
    logic [31:0]        w_sml;
    logic [23:0]        w_big_man;
    logic [23:0]        w_sml_man;
    logic [23:0]        w_sml_shift;
    logic [7:0]         w_exp_diff;

    logic [24:0]        w_sum;
    logic [23:0]        w_dif;
    logic [4:0]         w_lz;
    logic [23:0]        w_norm_man;
    logic [23:0]        w_res_man;
    logic signed [9:0]  w_res_exp;
    logic               w_sat;
    logic               w_zero_res;
    logic [31:0]        w_result;

    assign w_accept  = in_valid && r_in_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign acc_out   = r_acc;
    assign acc_cnt   = r_cnt;

    // Next-state selection; a clear aborts any in-flight op but still honours an IDLE accept
    always_comb begin
        w_next_state = r_state;
        if (acc_clear) begin
            if ((r_state == S_IDLE) && w_accept) begin
                w_next_state = S_ALIGN;
            end else begin
                w_next_state = S_IDLE;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_next_state = S_ALIGN;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
                S_ALIGN: w_next_state = S_ADD;
                S_ADD:   w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Alignment: pick the larger magnitude as base, shift the other (denormals read as zero)
    always_comb begin
        w_a_zero = (r_acc[30:23] == 8'd0);
        w_b_zero = (r_op[30:23] == 8'd0);
        w_a_mag  = w_a_zero ? 31'd0 : r_acc[30:0];
        w_b_mag  = w_b_zero ? 31'd0 : r_op[30:0];
        if (w_b_mag > w_a_mag) begin
            w_big      = r_op;
            w_sml      = r_acc;
            w_big_zero = w_b_zero;
            w_sml_zero = w_a_zero;
        end else begin
            w_big      = r_acc;
            w_sml      = r_op;
            w_big_zero = w_a_zero;
            w_sml_zero = w_b_zero;
        end
        w_big_man  = w_big_zero ? 24'd0 : {1'b1, w_big[22:0]};
        w_sml_man  = w_sml_zero ? 24'd0 : {1'b1, w_sml[22:0]};
        w_exp_diff = w_big[30:23] - w_sml[30:23];
        if (w_exp_diff >= 8'd25) begin
            w_sml_shift = 24'd0;
        end else begin
            w_sml_shift = w_sml_man >> w_exp_diff;
        end
    end

    // Mantissa add/subtract, normalisation and saturation/flush of the result
    always_comb begin
        w_sum      = {1'b0, r_big_man} + {1'b0, r_sml_man};
        w_dif      = r_big_man - r_sml_man;
        w_lz       = lzc24(w_dif);
        w_norm_man = w_dif << w_lz;
        if (r_sub) begin
            w_res_man = w_norm_man;
            w_res_exp = $signed({2'b00, r_big_exp}) - $signed({5'b00000, w_lz});
        end else if (w_sum[24]) begin
            w_res_man = w_sum[24:1];
            w_res_exp = $signed({2'b00, r_big_exp}) + 10'sd1;
        end else begin
            w_res_man = w_sum[23:0];
            w_res_exp = $signed({2'b00, r_big_exp});
        end
        w_zero_res = (w_res_man == 24'd0) || (w_res_exp <= 10'sd0);
        w_sat      = (w_res_man != 24'd0) && (w_res_exp >= 10'sd255);
        if (w_sat) begin
            w_result = {r_res_sign, 31'h7F7FFFFF};
        end else if (w_zero_res) begin
            w_result = 32'h00000000;
        end else begin
            w_result = {r_res_sign, w_res_exp[7:0], w_res_man[22:0]};
        end
    end

    // State, handshake, sum and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= 32'd0;
            r_cnt       <= {CNT_W{1'b0}};
            r_op        <= 32'd0;
        end else begin
            r_state     <= w_next_state;
            r_in_ready  <= (w_next_state == S_IDLE);
            r_out_valid <= (r_state == S_ADD) && !acc_clear;
            if (acc_clear) begin
                r_acc <= 32'd0;
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_state == S_ADD) begin
                r_acc <= w_result;
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_acc <= r_acc;
                r_cnt <= r_cnt;
            end
            if (w_accept) begin
                r_op <= in_data;
            end else begin
                r_op <= r_op;
            end
        end
    end

    // Aligned operand registers captured at the end of ALIGN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_sign <= 1'b0;
            r_sub      <= 1'b0;
            r_big_exp  <= 8'd0;
            r_big_man  <= 24'd0;
            r_sml_man  <= 24'd0;
        end else if (r_state == S_ALIGN) begin
            r_res_sign <= w_big[31];
            r_sub      <= w_big[31] ^ w_sml[31];
            r_big_exp  <= w_big[30:23];
            r_big_man  <= w_big_man;
            r_sml_man  <= w_sml_shift;
        end else begin
            r_res_sign <= r_res_sign;
            r_sub      <= r_sub;
            r_big_exp  <= r_big_exp;
            r_big_man  <= r_big_man;
            r_sml_man  <= r_sml_man;
        end
    end

`ifdef FPACC_OVF_FLAG_EN
    logic r_ovf;

    // Sticky saturation flag, cleared only by acc_clear or reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (acc_clear) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_ADD) && w_sat) begin
            r_ovf <= 1'b1;
        end else begin
            r_ovf <= r_ovf;
        end
    end

    assign acc_ovf = r_ovf;
`endif

endmodule
